// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped countdown timer with prescaler, auto-reload and level interrupt
module mmio_timer #(
    parameter int CNT_W    = 32,
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic [3:0]  be,
    input  logic        wren,
    output logic [31:0] dout,
    output logic        irq
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;
    state_t state, state_nx;
    logic en, auto_rl, ie, done;
    logic [CNT_W-1:0] preset, count;
    logic [PW-1:0] presc;
    logic wr, ctrl_wr, en_rise, en_fall, tick, expire;
    logic [31:0] preset_wr;
    logic unused_addr;
    assign unused_addr = ^{addr[31:4], addr[1:0]};
    assign wr      = sel & wren;
    assign ctrl_wr = wr & (addr[3:2] == 2'd0) & be[0];
    assign en_rise = ctrl_wr & din[0] & ~en;
    assign en_fall = ctrl_wr & ~din[0] & en;
    assign tick    = (state == RUN) && (presc == PW'(PRESCALE - 1));
    assign expire  = tick && (count == '0);
    assign irq     = done & ie;
    always_comb begin
        state_nx = en_fall ? IDLE :
                   ((state == IDLE || state == HOLD) && en_rise) ? LOAD :
                   (state == LOAD) ? RUN :
                   (expire && !auto_rl) ? HOLD : state;
    end
    always_comb begin
        preset_wr = 32'(preset);
        for (int i = 0; i < 4; i++)
            if (be[i]) preset_wr[8*i +: 8] = din[8*i +: 8];
    end
    always_comb begin
        dout = !sel ? 32'h0 :
               (addr[3:2] == 2'd0) ? {29'h0, ie, auto_rl, en} :
               (addr[3:2] == 2'd1) ? 32'(preset) :
               (addr[3:2] == 2'd2) ? 32'(count) : {31'h0, done};
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            en      <= 1'b0;
            auto_rl <= 1'b0;
            ie      <= 1'b0;
            done    <= 1'b0;
            preset  <= '0;
            count   <= '0;
            presc   <= '0;
        end else begin
            state <= state_nx;
            if (ctrl_wr) begin
                en      <= din[0];
                auto_rl <= din[1];
                ie      <= din[2];
            end
            // a one-shot expiry retires EN even if software rewrites EN=1 that cycle
            if (expire && !auto_rl) en <= 1'b0;
            if (wr && addr[3:2] == 2'd1) preset <= CNT_W'(preset_wr);
            if (wr && addr[3:2] == 2'd3 && be[0] && din[0]) done <= 1'b0;
            if (expire) done <= 1'b1;
            if (!en_fall) begin
                if (state == LOAD) begin
                    count <= preset;
                    presc <= '0;
                end else if (state == RUN) begin
                    presc <= tick ? '0 : presc + 1'b1;
                    if (tick) count <= (count != '0) ? count - 1'b1 : auto_rl ? preset : count;
                end
            end
        end
    end
endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: directed checks of mmio_timer with PRESCALE=1 and PRESCALE=4 instances
`timescale 1ns/1ps
module tb_mmio_timer;
    logic clk = 1'b0;
    logic rst;
    logic sel, sel4, wren;
    logic [31:0] addr, din, dout, dout4;
    logic [3:0] be;
    logic irq, irq4;
    int checks = 0;
    int failures = 0;

    mmio_timer #(.CNT_W(32), .PRESCALE(1)) dut (
        .clk(clk), .rst(rst), .sel(sel), .addr(addr), .din(din),
        .be(be), .wren(wren), .dout(dout), .irq(irq)
    );
    mmio_timer #(.CNT_W(32), .PRESCALE(4)) dut4 (
        .clk(clk), .rst(rst), .sel(sel4), .addr(addr), .din(din),
        .be(be), .wren(wren), .dout(dout4), .irq(irq4)
    );

    always #50 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input bit t, input logic [1:0] r, input logic [31:0] d, input logic [3:0] b);
        sel = !t; sel4 = t; wren = 1'b1; addr = {28'h0, r, 2'b00}; din = d; be = b;
        @(negedge clk);
        sel = 1'b0; sel4 = 1'b0; wren = 1'b0; din = 32'h0; be = 4'h0;
    endtask

    task automatic rd(input bit t, input logic [1:0] r, input logic [31:0] exp, input string tag);
        logic [31:0] v;
        sel = !t; sel4 = t; wren = 1'b0; addr = {28'h0, r, 2'b00};
        #1;
        v = t ? dout4 : dout;
        sel = 1'b0; sel4 = 1'b0;
        chk(tag, v, exp);
    endtask

    initial begin
        rst = 1'b0; sel = 1'b0; sel4 = 1'b0; wren = 1'b0;
        addr = 32'h0; din = 32'h0; be = 4'h0;
        cyc(2);
        rst = 1'b1;
        rd(0, 2'd0, 32'h0, "rst_ctrl");
        rd(0, 2'd1, 32'h0, "rst_preset");
        rd(0, 2'd2, 32'h0, "rst_count");
        rd(0, 2'd3, 32'h0, "rst_status");
        chk("rst_irq", {31'h0, irq}, 32'h0);
        addr = 32'h4; #1;
        chk("nosel_dout", dout, 32'h0);

        // one-shot, PRESET=5: DONE after LOAD + 6 ticks
        wr(0, 2'd1, 32'd5, 4'hF);
        wr(0, 2'd0, 32'h5, 4'h1);
        cyc(6);
        rd(0, 2'd3, 32'h0, "os_done_e6");
        rd(0, 2'd2, 32'h0, "os_count_e6");
        chk("os_irq_e6", {31'h0, irq}, 32'h0);
        cyc(1);
        rd(0, 2'd3, 32'h1, "os_done_e7");
        chk("os_irq_e7", {31'h0, irq}, 32'h1);
        rd(0, 2'd0, 32'h4, "os_ctrl");
        rd(0, 2'd2, 32'h0, "os_count");
        cyc(2);
        rd(0, 2'd2, 32'h0, "os_hold_count");
        wr(0, 2'd3, 32'h1, 4'h1);
        rd(0, 2'd3, 32'h0, "os_w1c");
        chk("os_irq_clr", {31'h0, irq}, 32'h0);

        // auto reload, PRESET=2
        wr(0, 2'd1, 32'd2, 4'hF);
        wr(0, 2'd0, 32'h3, 4'h1);
        cyc(1);
        rd(0, 2'd2, 32'd2, "ar_cnt_e1");
        cyc(1);
        rd(0, 2'd2, 32'd1, "ar_cnt_e2");
        cyc(1);
        rd(0, 2'd2, 32'd0, "ar_cnt_e3");
        rd(0, 2'd3, 32'h0, "ar_done_e3");
        cyc(1);
        rd(0, 2'd2, 32'd2, "ar_cnt_e4");
        rd(0, 2'd3, 32'h1, "ar_done_e4");
        chk("ar_irq_noie", {31'h0, irq}, 32'h0);
        wr(0, 2'd3, 32'h1, 4'h1);
        rd(0, 2'd3, 32'h0, "ar_w1c");
        rd(0, 2'd2, 32'd1, "ar_cnt_e5");
        cyc(1);
        rd(0, 2'd2, 32'd0, "ar_cnt_e6");
        wr(0, 2'd3, 32'h1, 4'h1);
        rd(0, 2'd3, 32'h1, "ar_w1c_vs_set");
        rd(0, 2'd2, 32'd2, "ar_cnt_e7");
        wr(0, 2'd0, 32'h3, 4'h1);
        cyc(1);
        rd(0, 2'd2, 32'd0, "ar_no_restart");
        cyc(1);
        wr(0, 2'd3, 32'h1, 4'h1);
        rd(0, 2'd3, 32'h0, "ar_w1c2");
        cyc(1);
        rd(0, 2'd2, 32'd0, "ar_cnt_e12");
        wr(0, 2'd0, 32'h2, 4'h1);
        rd(0, 2'd3, 32'h1, "stop_at_expiry_done");
        rd(0, 2'd2, 32'd0, "stop_at_expiry_cnt");
        rd(0, 2'd0, 32'h2, "stop_at_expiry_ctrl");
        cyc(2);
        rd(0, 2'd2, 32'd0, "idle_frozen");
        wr(0, 2'd3, 32'h1, 4'h1);

        // byte lanes
        wr(0, 2'd1, 32'h11223344, 4'hF);
        wr(0, 2'd1, 32'hAABBCCDD, 4'b0101);
        rd(0, 2'd1, 32'h11BB33DD, "be_0101");
        wr(0, 2'd1, 32'hFFFFFFFF, 4'h0);
        rd(0, 2'd1, 32'h11BB33DD, "be_0000");
        wr(0, 2'd2, 32'h12345678, 4'hF);
        rd(0, 2'd2, 32'd0, "count_ro");

        // stop mid-run, re-enable reloads, reset mid-run
        wr(0, 2'd1, 32'd10, 4'hF);
        wr(0, 2'd0, 32'h1, 4'h1);
        cyc(8);
        rd(0, 2'd2, 32'd3, "mid_cnt3");
        wr(0, 2'd0, 32'h0, 4'h1);
        rd(0, 2'd2, 32'd3, "mid_frozen");
        cyc(3);
        rd(0, 2'd2, 32'd3, "mid_frozen2");
        rd(0, 2'd3, 32'h0, "mid_no_done");
        wr(0, 2'd0, 32'h1, 4'h1);
        cyc(1);
        rd(0, 2'd2, 32'd10, "reen_reload");
        cyc(2);
        rd(0, 2'd2, 32'd8, "reen_run");
        rst = 1'b0;
        rd(0, 2'd2, 32'd0, "arst_count");
        rd(0, 2'd0, 32'd0, "arst_ctrl");
        rd(0, 2'd1, 32'd0, "arst_preset");
        rd(0, 2'd3, 32'd0, "arst_status");
        chk("arst_irq", {31'h0, irq}, 32'h0);
        cyc(1);
        rst = 1'b1;

        // PRESCALE=4 instance
        wr(1, 2'd1, 32'd1, 4'hF);
        wr(1, 2'd0, 32'h7, 4'h1);
        cyc(8);
        rd(1, 2'd3, 32'h0, "ps_done_e8");
        chk("ps_irq_e8", {31'h0, irq4}, 32'h0);
        cyc(1);
        rd(1, 2'd3, 32'h1, "ps_done_e9");
        chk("ps_irq_e9", {31'h0, irq4}, 32'h1);
        rd(1, 2'd2, 32'd1, "ps_reload");
        wr(1, 2'd1, 32'd9, 4'hF);
        wr(1, 2'd3, 32'h1, 4'h1);
        rd(1, 2'd2, 32'd1, "ps_cnt_unaffected");
        cyc(5);
        rd(1, 2'd3, 32'h0, "ps_done_e16");
        cyc(1);
        rd(1, 2'd3, 32'h1, "ps_done_e17");
        rd(1, 2'd2, 32'd9, "ps_new_preset");
        wr(1, 2'd3, 32'h1, 4'h1);
        cyc(38);
        rd(1, 2'd3, 32'h0, "ps_done_e56");
        cyc(1);
        rd(1, 2'd3, 32'h1, "ps_done_e57");
        chk("ps_irq_e57", {31'h0, irq4}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
